// File: rtl/id_alu_ctrl.sv
// Decode stage ALU control for RV32I with the ID/EX pipeline register.
// Decodes the instruction into an ALU opcode, operand select, immediate and
// writeback control, then registers the result with stall/flush/reset handling.
module id_alu_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        in_valid,
   input  logic        stall,
   input  logic        flush,
   output logic [4:0]  ALU_ctrl,
   output logic        alu_src_imm,
   output logic [31:0] imm,
   output logic [4:0]  rd_addr,
   output logic        reg_write,
   output logic        is_branch,
   output logic        illegal,
   output logic        out_valid
);

   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;

   localparam logic [4:0] AluAdd     = 5'd0;
   localparam logic [4:0] AluSub     = 5'd1;
   localparam logic [4:0] AluSll     = 5'd2;
   localparam logic [4:0] AluSlt     = 5'd3;
   localparam logic [4:0] AluSltu    = 5'd4;
   localparam logic [4:0] AluXor     = 5'd5;
   localparam logic [4:0] AluSrl     = 5'd6;
   localparam logic [4:0] AluSra     = 5'd7;
   localparam logic [4:0] AluOr      = 5'd8;
   localparam logic [4:0] AluAnd     = 5'd9;
   localparam logic [4:0] AluBeq     = 5'd10;
   localparam logic [4:0] AluBne     = 5'd11;
   localparam logic [4:0] AluBlt     = 5'd12;
   localparam logic [4:0] AluBge     = 5'd13;
   localparam logic [4:0] AluBltu    = 5'd14;
   localparam logic [4:0] AluBgeu    = 5'd15;
   localparam logic [4:0] AluIllegal = 5'd31;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        f7_zero;
   logic        f7_alt;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode  = instr[6:0];
   assign funct3  = instr[14:12];
   assign f7_zero = (instr[31:25] == 7'h00);
   assign f7_alt  = (instr[31:25] == 7'h20);

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   logic [4:0]  base_code;
   logic [4:0]  br_code;
   logic        br_bad;

   // Base ALU code for register/immediate arithmetic and compare code for branches.
   always_comb begin
      base_code = AluAdd;
      br_code   = AluBeq;
      br_bad    = 1'b0;
      unique case (funct3)
         3'b000: begin base_code = AluAdd;  br_code = AluBeq;  end
         3'b001: begin base_code = AluSll;  br_code = AluBne;  end
         3'b010: begin base_code = AluSlt;  br_bad  = 1'b1;    end
         3'b011: begin base_code = AluSltu; br_bad  = 1'b1;    end
         3'b100: begin base_code = AluXor;  br_code = AluBlt;  end
         3'b101: begin base_code = AluSrl;  br_code = AluBge;  end
         3'b110: begin base_code = AluOr;   br_code = AluBltu; end
         3'b111: begin base_code = AluAnd;  br_code = AluBgeu; end
         default: ;
      endcase
   end

   logic [4:0]  dec_alu;
   logic        dec_src_imm;
   logic [31:0] dec_imm;
   logic [4:0]  dec_rd;
   logic        dec_wr;
   logic        dec_br;
   logic        dec_ill;

   // Full instruction decode; illegal encodings collapse to a uniform illegal result.
   always_comb begin
      dec_alu     = AluAdd;
      dec_src_imm = 1'b0;
      dec_imm     = 32'd0;
      dec_wr      = 1'b0;
      dec_br      = 1'b0;
      dec_ill     = 1'b0;
      case (opcode)
         OpcOp: begin
            dec_wr = 1'b1;
            if (f7_zero) begin
               dec_alu = base_code;
            end else if (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)) begin
               dec_alu = (funct3 == 3'b000) ? AluSub : AluSra;
            end else begin
               dec_ill = 1'b1;
            end
         end
         OpcOpImm: begin
            dec_wr      = 1'b1;
            dec_src_imm = 1'b1;
            dec_imm     = imm_i;
            dec_alu     = base_code;
            if (funct3 == 3'b001 && !f7_zero) dec_ill = 1'b1;
            if (funct3 == 3'b101) begin
               if (f7_alt) dec_alu = AluSra;
               else if (!f7_zero) dec_ill = 1'b1;
            end
         end
         OpcLoad, OpcJalr: begin
            dec_wr = 1'b1; dec_src_imm = 1'b1; dec_imm = imm_i;
         end
         OpcStore: begin
            dec_src_imm = 1'b1; dec_imm = imm_s;
         end
         OpcJal: begin
            dec_wr = 1'b1; dec_src_imm = 1'b1; dec_imm = imm_j;
         end
         OpcLui, OpcAuipc: begin
            dec_wr = 1'b1; dec_src_imm = 1'b1; dec_imm = imm_u;
         end
         OpcBranch: begin
            dec_br  = 1'b1;
            dec_imm = imm_b;
            dec_alu = br_code;
            dec_ill = br_bad;
         end
         default: dec_ill = 1'b1;
      endcase
      if (dec_ill) begin
         dec_alu     = AluIllegal;
         dec_wr      = 1'b0;
         dec_br      = 1'b0;
         dec_src_imm = 1'b0;
         dec_imm     = 32'd0;
      end
      // Only a real destination is forwarded; stores/branches reuse these bits as imm.
      dec_rd = dec_wr ? instr[11:7] : 5'd0;
   end

   logic [4:0]  alu_q;
   logic        src_imm_q;
   logic [31:0] imm_q;
   logic [4:0]  rd_q;
   logic        wr_q, br_q, ill_q, vld_q;

   // ID/EX register: reset > flush > stall(hold) > load decode or bubble.
   always_ff @(posedge clk) begin
      if (!rst_n || flush || (!stall && !in_valid)) begin
         alu_q     <= AluAdd;
         src_imm_q <= 1'b0;
         imm_q     <= 32'd0;
         rd_q      <= 5'd0;
         wr_q      <= 1'b0;
         br_q      <= 1'b0;
         ill_q     <= 1'b0;
         vld_q     <= 1'b0;
      end else if (!stall) begin
         alu_q     <= dec_alu;
         src_imm_q <= dec_src_imm;
         imm_q     <= dec_imm;
         rd_q      <= dec_rd;
         wr_q      <= dec_wr;
         br_q      <= dec_br;
         ill_q     <= dec_ill;
         vld_q     <= 1'b1;
      end
   end

   assign ALU_ctrl    = alu_q;
   assign alu_src_imm = src_imm_q;
   assign imm         = imm_q;
   assign rd_addr     = rd_q;
   assign reg_write   = wr_q;
   assign is_branch   = br_q;
   assign illegal     = ill_q;
   assign out_valid   = vld_q;

endmodule
